// File: rtl/fpu_ctl_pkg.sv
// fpu_ctl_pkg: shared opcodes, integer-destination funct5 codes and sequencer state encoding
package fpu_ctl_pkg;
    localparam logic [6:0] OPC_OP_FP  = 7'b1010011;
    localparam logic [6:0] OPC_FMADD  = 7'b1000011;
    localparam logic [6:0] OPC_FMSUB  = 7'b1000111;
    localparam logic [6:0] OPC_FNMSUB = 7'b1001011;
    localparam logic [6:0] OPC_FNMADD = 7'b1001111;
    // OP-FP groups whose result lands in the integer register file
    localparam logic [4:0] F5_CMP     = 5'b10100;
    localparam logic [4:0] F5_CVT_INT = 5'b11000;
    localparam logic [4:0] F5_MV_X    = 5'b11100;
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;
endpackage

// File: rtl/fpu_inst_classify.sv
// fpu_inst_classify: decodes an instruction word into FP/scalar class and register fields
module fpu_inst_classify
    import fpu_ctl_pkg::*;
(
    input  logic [31:0] inst,
    output logic        is_fp,
    output logic        wr_int,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2
);
    logic [6:0] opc;
    logic [4:0] f5;
    assign opc    = inst[6:0];
    assign f5     = inst[31:27];
    assign is_fp  = opc inside {OPC_OP_FP, OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD};
    assign wr_int = (opc == OPC_OP_FP) && (f5 inside {F5_CMP, F5_CVT_INT, F5_MV_X});
    assign rd     = inst[11:7];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
endmodule

// File: rtl/fpu_issue_ctl.sv
// fpu_issue_ctl: single-issue sequencer holding one FP op in flight while scalar ops bypass it
module fpu_issue_ctl
    import fpu_ctl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             inst_valid,
    input  logic [31:0]      inst,
    output logic             inst_ready,
    input  logic             halt_req,
    output logic             fpu_issue,
    output logic [31:0]      fpu_inst,
    input  logic             fpu_complete,
    output logic             scalar_issue,
    output logic [31:0]      scalar_inst,
    output logic             busy,
    output logic             stall_scalar,
    output logic             timeout_err,
    input  logic             clr_err,
    output logic [CNT_W-1:0] retire_cnt
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    state_e           state_q, state_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             fpu_issue_q, fpu_issue_d;
    logic             scalar_issue_q, scalar_issue_d;
    logic [31:0]      fpu_inst_q, fpu_inst_d;
    logic [31:0]      scalar_inst_q, scalar_inst_d;
    logic             pend_wr_q, pend_wr_d;
    logic [4:0]       pend_rd_q, pend_rd_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       c_is_fp, c_wr_int;
    logic [4:0] c_rd, c_rs1, c_rs2;
    logic       hazard, accept, tmo_hit;

    fpu_inst_classify u_cls (
        .inst   (inst),
        .is_fp  (c_is_fp),
        .wr_int (c_wr_int),
        .rd     (c_rd),
        .rs1    (c_rs1),
        .rs2    (c_rs2)
    );

    assign busy         = (state_q == WAIT);
    assign stall_scalar = busy & ~fpu_complete;
    assign fpu_issue    = fpu_issue_q;
    assign scalar_issue = scalar_issue_q;
    assign fpu_inst     = fpu_inst_q;
    assign scalar_inst  = scalar_inst_q;
    assign timeout_err  = err_q;
    assign retire_cnt   = cnt_q;

    // Acceptance, hazard check, timeout watchdog and retire bookkeeping
    always_comb begin
        state_d        = state_q;
        tmo_d          = tmo_q;
        fpu_issue_d    = 1'b0;
        scalar_issue_d = 1'b0;
        fpu_inst_d     = fpu_inst_q;
        scalar_inst_d  = scalar_inst_q;
        pend_wr_d      = pend_wr_q;
        pend_rd_d      = pend_rd_q;
        err_d          = err_q & ~clr_err;
        cnt_d          = cnt_q;
        // a completing op has its result ready this cycle, so it no longer blocks readers
        hazard     = stall_scalar & pend_wr_q & (pend_rd_q != 5'd0) &
                     ((c_rs1 == pend_rd_q) | (c_rs2 == pend_rd_q) | (c_rd == pend_rd_q));
        inst_ready = ~halt_req & (busy ? (c_is_fp ? fpu_complete : ~hazard) : 1'b1);
        accept     = inst_valid & inst_ready;
        tmo_hit    = stall_scalar & (tmo_q == TW'(TIMEOUT_CYCLES - 1));
        if (busy) begin
            if (fpu_complete) begin
                state_d = IDLE;
                cnt_d   = cnt_q + CNT_W'(1);
            end else if (tmo_hit) begin
                state_d = IDLE;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
        if (accept & c_is_fp) begin
            state_d     = WAIT;
            tmo_d       = '0;
            fpu_issue_d = 1'b1;
            fpu_inst_d  = inst;
            pend_wr_d   = c_wr_int;
            pend_rd_d   = c_rd;
        end
        if (accept & ~c_is_fp) begin
            scalar_issue_d = 1'b1;
            scalar_inst_d  = inst;
        end
    end

    // State and output registers; reset drops any in-flight op
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q        <= IDLE;
            tmo_q          <= '0;
            fpu_issue_q    <= 1'b0;
            scalar_issue_q <= 1'b0;
            fpu_inst_q     <= '0;
            scalar_inst_q  <= '0;
            pend_wr_q      <= 1'b0;
            pend_rd_q      <= '0;
            err_q          <= 1'b0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            tmo_q          <= tmo_d;
            fpu_issue_q    <= fpu_issue_d;
            scalar_issue_q <= scalar_issue_d;
            fpu_inst_q     <= fpu_inst_d;
            scalar_inst_q  <= scalar_inst_d;
            pend_wr_q      <= pend_wr_d;
            pend_rd_q      <= pend_rd_d;
            err_q          <= err_d;
            cnt_q          <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fpu_issue_ctl.sv
// tb_fpu_issue_ctl: table-driven per-cycle vectors plus hand sequences for timeout and reset
module tb_fpu_issue_ctl;
    localparam logic [31:0] FADD = 32'h002081D3;
    localparam logic [31:0] FEQ  = 32'hA020A353;
    localparam logic [31:0] ADD7 = 32'h000303B3;
    localparam logic [31:0] ADDI = 32'h00100293;

    logic        clk = 1'b0;
    logic        rst_l, inst_valid, halt_req, fpu_complete, clr_err;
    logic [31:0] inst;
    logic        inst_ready, fpu_issue, scalar_issue, busy, stall_scalar, timeout_err;
    logic [31:0] fpu_inst, scalar_inst;
    logic [15:0] retire_cnt;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic        v;
        logic [31:0] inst;
        logic        halt, cmp, clr;
        logic        rdy, fi, si, busy, stall, err;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[24];

    fpu_issue_ctl #(.TIMEOUT_CYCLES(64), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_ready   (inst_ready),
        .halt_req     (halt_req),
        .fpu_issue    (fpu_issue),
        .fpu_inst     (fpu_inst),
        .fpu_complete (fpu_complete),
        .scalar_issue (scalar_issue),
        .scalar_inst  (scalar_inst),
        .busy         (busy),
        .stall_scalar (stall_scalar),
        .timeout_err  (timeout_err),
        .clr_err      (clr_err),
        .retire_cnt   (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic [15:0] base;
        rst_l = 1'b0; inst_valid = 1'b0; inst = '0; halt_req = 1'b0; fpu_complete = 1'b0; clr_err = 1'b0;
        //          v  inst  halt cmp clr  rdy fi si busy stall err cnt
        tbl[0]  = '{1'b1, FADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[1]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
        tbl[2]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
        tbl[3]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[4]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[5]  = '{1'b1, FEQ,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[6]  = '{1'b1, ADD7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
        tbl[7]  = '{1'b1, ADDI, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
        tbl[8]  = '{1'b1, ADD7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1};
        tbl[9]  = '{1'b1, ADD7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1};
        tbl[10] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
        tbl[11] = '{1'b1, FADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};
        tbl[12] = '{1'b1, FADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2};
        tbl[13] = '{1'b1, FADD, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2};
        tbl[14] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd3};
        tbl[15] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3};
        tbl[16] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4};
        tbl[17] = '{1'b1, FADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4};
        tbl[18] = '{1'b1, FADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4};
        tbl[19] = '{1'b1, FADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4};
        tbl[20] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd4};
        tbl[21] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5};
        tbl[22] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5};
        tbl[23] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5};

        repeat (2) @(posedge clk);
        #1;
        chk("rst.fpu_issue", {31'b0, fpu_issue}, 32'd0);
        chk("rst.scalar_issue", {31'b0, scalar_issue}, 32'd0);
        chk("rst.busy", {31'b0, busy}, 32'd0);
        chk("rst.timeout_err", {31'b0, timeout_err}, 32'd0);
        chk("rst.retire_cnt", {16'b0, retire_cnt}, 32'd0);
        chk("rst.fpu_inst", fpu_inst, 32'd0);
        chk("rst.scalar_inst", scalar_inst, 32'd0);
        rst_l = 1'b1;
        next_cycle();

        for (int i = 0; i < 24; i++) begin
            inst_valid = tbl[i].v; inst = tbl[i].inst; halt_req = tbl[i].halt;
            fpu_complete = tbl[i].cmp; clr_err = tbl[i].clr;
            @(negedge clk);
            chk($sformatf("v%0d.inst_ready", i), {31'b0, inst_ready}, {31'b0, tbl[i].rdy});
            chk($sformatf("v%0d.fpu_issue", i), {31'b0, fpu_issue}, {31'b0, tbl[i].fi});
            chk($sformatf("v%0d.scalar_issue", i), {31'b0, scalar_issue}, {31'b0, tbl[i].si});
            chk($sformatf("v%0d.busy", i), {31'b0, busy}, {31'b0, tbl[i].busy});
            chk($sformatf("v%0d.stall_scalar", i), {31'b0, stall_scalar}, {31'b0, tbl[i].stall});
            chk($sformatf("v%0d.timeout_err", i), {31'b0, timeout_err}, {31'b0, tbl[i].err});
            chk($sformatf("v%0d.retire_cnt", i), {16'b0, retire_cnt}, {16'b0, tbl[i].cnt});
            next_cycle();
        end
        inst_valid = 1'b0; inst = '0; halt_req = 1'b0; fpu_complete = 1'b0; clr_err = 1'b0;
        chk("tbl.scalar_inst", scalar_inst, ADD7);
        chk("tbl.fpu_inst", fpu_inst, FADD);

        // timeout with no completion: 64 WAIT cycles then abandon
        base = retire_cnt;
        inst_valid = 1'b1; inst = FADD;
        next_cycle();
        inst_valid = 1'b0; inst = '0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            if (n == 32) chk("to.fpu_inst_stable", fpu_inst, FADD);
            next_cycle();
        end
        chk("to.wait_cycles", n, 32'd64);
        chk("to.timeout_err", {31'b0, timeout_err}, 32'd1);
        chk("to.retire_cnt", {16'b0, retire_cnt}, {16'b0, base});
        clr_err = 1'b1;
        next_cycle();
        clr_err = 1'b0;
        chk("to.clr_err", {31'b0, timeout_err}, 32'd0);

        // completion in the would-be timeout cycle retires normally
        inst_valid = 1'b1; inst = FADD;
        next_cycle();
        inst_valid = 1'b0; inst = '0;
        repeat (63) next_cycle();
        chk("bnd.busy_before", {31'b0, busy}, 32'd1);
        fpu_complete = 1'b1;
        next_cycle();
        fpu_complete = 1'b0;
        chk("bnd.busy", {31'b0, busy}, 32'd0);
        chk("bnd.timeout_err", {31'b0, timeout_err}, 32'd0);
        chk("bnd.retire_cnt", {16'b0, retire_cnt}, {16'b0, base + 16'd1});

        // clr_err held through a fresh timeout: set wins
        clr_err = 1'b1;
        inst_valid = 1'b1; inst = FADD;
        next_cycle();
        inst_valid = 1'b0; inst = '0;
        repeat (63) next_cycle();
        chk("set_wins.before", {31'b0, timeout_err}, 32'd0);
        next_cycle();
        chk("set_wins.err", {31'b0, timeout_err}, 32'd1);
        chk("set_wins.busy", {31'b0, busy}, 32'd0);
        clr_err = 1'b0;

        // reset during WAIT drops the op; later completion in IDLE is ignored
        inst_valid = 1'b1; inst = FADD;
        next_cycle();
        inst_valid = 1'b0; inst = '0;
        chk("mid.busy", {31'b0, busy}, 32'd1);
        rst_l = 1'b0;
        #1;
        chk("mid.rst_busy", {31'b0, busy}, 32'd0);
        chk("mid.rst_fpu_issue", {31'b0, fpu_issue}, 32'd0);
        chk("mid.rst_fpu_inst", fpu_inst, 32'd0);
        chk("mid.rst_timeout_err", {31'b0, timeout_err}, 32'd0);
        chk("mid.rst_retire_cnt", {16'b0, retire_cnt}, 32'd0);
        next_cycle();
        rst_l = 1'b1;
        fpu_complete = 1'b1;
        next_cycle();
        fpu_complete = 1'b0;
        next_cycle();
        chk("idle_cmp.retire_cnt", {16'b0, retire_cnt}, 32'd0);
        chk("idle_cmp.busy", {31'b0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/fpu_issue_ctl.md
Name: fpu_issue_ctl

Overview:
- Single-issue sequencer between the instruction fetch/FSM stage and the FPU execution datapath.
- Accepts one 32-bit instruction per valid/ready handshake and classifies it as FP or scalar.
- FP ops go to the single FPU one at a time and are held until fpu_complete. Scalar ops may proceed past an in-flight FP op unless they hit an integer-register hazard.
- Watchdogs each FP op with a timeout and keeps a retired-op count.

Parameters:
TIMEOUT_CYCLES, 64, cycles in WAIT without fpu_complete before the op is abandoned (minimum 2).
CNT_W, 16, width of retired-FP-op counter.

Ports:
clk  input  1  system clock.
rst_l  input  1  asynchronous active-low reset.
inst_valid  input  1  fetch stage presents an instruction.
inst  input  32  instruction word.
inst_ready  output  1  combinational; accept when inst_valid & inst_ready.
halt_req  input  1  freezes acceptance; in-flight op still completes.
fpu_issue  output  1  one-cycle start pulse to the FPU.
fpu_inst  output  32  registered FP instruction, stable from the fpu_issue cycle until retire.
fpu_complete  input  1  FPU result valid (single-cycle pulse).
scalar_issue  output  1  one-cycle pulse: scalar instruction dispatched.
scalar_inst  output  32  registered scalar instruction.
busy  output  1  FP op in flight (state WAIT).
stall_scalar  output  1  busy & ~fpu_complete.
timeout_err  output  1  sticky timeout flag.
clr_err  input  1  clears timeout_err.
retire_cnt  output  CNT_W  FP ops completed, wraps modulo 2^CNT_W.

Behaviour:
- Reset: async on rst_l low. Forces state IDLE and clears every output register: fpu_issue, scalar_issue, fpu_inst, scalar_inst, timeout_err, retire_cnt, timeout counter and pending-rd register. Reset mid-op drops the op silently.
- Classification:
  - FP if opcode is 1010011 (OP-FP) or one of 1000011/1000111/1001011/1001111 (FMA family); otherwise scalar.
  - An FP op writes an integer rd if it is OP-FP with inst[31:27] in {10100, 11000, 11100}.
  - Scalar ops are conservatively treated as reading inst[19:15] and inst[24:20] and writing inst[11:7].
- States:
  - IDLE: inst_ready = ~halt_req. Accepted FP op → WAIT next cycle with fpu_issue=1 and fpu_inst loaded. Accepted scalar op → scalar_issue=1 next cycle; stays IDLE.
  - WAIT: a scalar op is accepted only if ~halt_req and there is no hazard. Hazard = the pending op writes an integer rd p≠0 and the scalar's rs1, rs2 or rd equals p. Accepting an FP op in WAIT requires fpu_complete in the same cycle (back-to-back issue): the old op retires and the new op issues next cycle, staying in WAIT.
  - WAIT with fpu_complete and no new FP accept → IDLE next cycle.
- Latency: acceptance at cycle N gives fpu_issue/scalar_issue at N+1. fpu_complete is accepted in any WAIT cycle, including the fpu_issue cycle. Retire: retire_cnt increments on the cycle after fpu_complete.
- fpu_complete while IDLE is ignored: no count change.
- Timeout:
  - Counter clears on entry to WAIT and increments each WAIT cycle without fpu_complete.
  - When it reaches TIMEOUT_CYCLES-1: timeout_err sets, state goes to IDLE, and retire_cnt is unchanged.
  - fpu_complete in the same cycle wins: normal retire, no error.
  - clr_err and a new timeout in the same cycle: set wins.
- Simultaneous: scalar acceptance and fpu_complete in the same cycle are both honoured. At most one instruction is accepted per cycle.
- halt_req does not mask fpu_complete or the timeout.

Decomposition:
- Package fpu_ctl_pkg holds:
  - opcode constants: OP-FP, FMADD, FMSUB, FNMSUB, FNMADD;
  - the int-dest funct5 list;
  - the state encoding IDLE/WAIT.
- Sub-module fpu_inst_classify (combinational): inst → is_fp, wr_int, rd, rs1, rs2.

Test Plan:
- Reset, then inst 0x002081D3 (fadd f3,f1,f2) accepted at N → fpu_issue=1 at N+1, busy=1; fpu_complete at N+3 → busy=0 at N+4, retire_cnt=1.
- Hazard: 0xA020A353 (feq x6,f1,f2) in flight, then 0x000303B3 (add x7,x6,x0) → inst_ready=0 until fpu_complete. Meanwhile 0x00100293 (addi x5,x0,1) is accepted → scalar_issue=1 while busy=1.
- Back-to-back: a second fadd held valid while WAIT → accepted only in the fpu_complete cycle; fpu_issue pulses again the next cycle; busy stays 1; retire_cnt=2 after the final completion.
- Timeout: TIMEOUT_CYCLES=64, fadd issued, no fpu_complete → timeout_err=1 and busy=0 after 64 WAIT cycles, retire_cnt unchanged. clr_err=1 for one cycle → timeout_err=0.
- halt_req=1 with inst_valid=1 → inst_ready=0, no issue pulses. Deassert → accepted next cycle.
- rst_l pulled low during WAIT → all outputs 0 immediately. A later fpu_complete in IDLE → retire_cnt stays 0.
